// File: rtl/kbd_matrix_scan_if.sv
// Key event handshake between the matrix scanner (master) and the CPU keyboard logic (slave).
interface kbd_matrix_scan_if;
  logic [6:0] key_code_o;
  logic       key_valid_o;
  logic       key_ack_in;
  logic       key_down_o;
  logic       key_overrun_o;

  modport master (
    output key_code_o, key_valid_o, key_down_o, key_overrun_o,
    input  key_ack_in
  );

  modport slave (
    input  key_code_o, key_valid_o, key_down_o, key_overrun_o,
    output key_ack_in
  );
endinterface

// File: rtl/kbd_matrix_scan.sv
// HP-67 keyboard matrix scanner: column strobe, row sync, frame debounce, key event handshake.
// Optional release events are built when KBD_RELEASE_EVENT_EN is defined.
module kbd_matrix_scan #(
  parameter int SETTLE_CYCLES  = 8,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk_in,
  input  logic              reset_in,
  output logic [4:0]        kbd_columns_o,
  input  logic [3:0]        rowsl_in,
  input  logic [3:0]        rowsr_in,
  kbd_matrix_scan_if.master kbd
);

  localparam int            SW          = $clog2(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]    DEB_TARGET  = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD} state_t;

  logic [7:0] row_meta, row_sync;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      row_meta <= '0;
      row_sync <= '0;
    end else begin
      row_meta <= {rowsr_in, rowsl_in};
      row_sync <= row_meta;
    end
  end

  // Column sequencer; 'run' gives column 0 a full window on the first frame after reset.
  logic          run;
  logic [SW-1:0] settle_cnt;
  logic [2:0]    col_idx, col_adv;
  logic          sample, frame_end;

  assign sample    = run && (settle_cnt == SETTLE_LAST);
  assign frame_end = sample && (col_idx == 3'd4);
  assign col_adv   = (col_idx == 3'd4) ? 3'd0 : col_idx + 3'd1;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      run           <= 1'b0;
      settle_cnt    <= '0;
      col_idx       <= '0;
      kbd_columns_o <= '0;
    end else begin
      run <= 1'b1;
      if (sample) begin
        settle_cnt    <= '0;
        col_idx       <= col_adv;
        kbd_columns_o <= 5'b00001 << col_adv;
      end else begin
        if (run) settle_cnt <= settle_cnt + SW'(1);
        kbd_columns_o <= 5'b00001 << col_idx;
      end
    end
  end

  logic [1:0] hit_cnt, hit_sum;
  logic [3:0] hit_total, row_pop;
  logic [2:0] row_low;
  logic [5:0] hit_code, hit_code_nxt;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    row_pop = '0;
    row_low = '0;
    for (int i = 7; i >= 0; i--) begin
      if (row_sync[i]) row_low = 3'(i);
    end
    for (int i = 0; i < 8; i++) begin
      row_pop = row_pop + 4'(row_sync[i]);
    end
    hit_total    = {2'b00, hit_cnt} + row_pop;
    hit_sum      = (hit_total >= 4'd2) ? 2'd2 : hit_total[1:0];
    hit_code_nxt = ((hit_cnt == 2'd0) && (row_sync != 8'd0)) ? {col_idx, row_low} : hit_code;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in || frame_end) begin
      hit_cnt  <= '0;
      hit_code <= '0;
    end else if (sample) begin
      hit_cnt  <= hit_sum;
      hit_code <= hit_code_nxt;
    end
  end

  // Frame verdict is only meaningful on frame_end, where it includes column 4's rows.
  logic frame_single, frame_empty;
  assign frame_single = (hit_sum == 2'd1);
  assign frame_empty  = (hit_sum == 2'd0);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt, cnt_inc;
  logic [5:0] cand, cand_nxt;
  logic       emit;
  logic [6:0] emit_code;

  assign cnt_inc = cnt + 4'd1;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state <= S_SCAN;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cand  <= cand_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    emit      = 1'b0;
    emit_code = '0;
    if (frame_end) begin
      unique case (state)
        S_SCAN: begin
          if (frame_single) begin
            cand_nxt = hit_code_nxt;
            if (DEB_TARGET == 4'd1) begin
              emit      = 1'b1;
              emit_code = {1'b0, hit_code_nxt};
              cnt_nxt   = '0;
              state_nxt = S_HELD;
            end else begin
              cnt_nxt   = 4'd1;
              state_nxt = S_DEBOUNCE;
            end
          end
        end
        S_DEBOUNCE: begin
          if (frame_single && (hit_code_nxt == cand)) begin
            if (cnt_inc == DEB_TARGET) begin
              emit      = 1'b1;
              emit_code = {1'b0, cand};
              cnt_nxt   = '0;
              state_nxt = S_HELD;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            cnt_nxt   = '0;
            state_nxt = S_SCAN;
          end
        end
        S_HELD: begin
          if (frame_empty) begin
            if (cnt_inc == DEB_TARGET) begin
              cnt_nxt   = '0;
              state_nxt = S_SCAN;
`ifdef KBD_RELEASE_EVENT_EN
              emit      = 1'b1;
              emit_code = {1'b1, cand};
`endif
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            cnt_nxt = '0;
          end
        end
        default: state_nxt = S_SCAN;
      endcase
    end
  end

  assign kbd.key_down_o = (state == S_HELD);

  // A pending unacknowledged event wins; a new one arriving then is dropped and flagged.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      kbd.key_code_o    <= '0;
      kbd.key_valid_o   <= 1'b0;
      kbd.key_overrun_o <= 1'b0;
    end else begin
      kbd.key_overrun_o <= 1'b0;
      if (emit) begin
        if (!kbd.key_valid_o || kbd.key_ack_in) begin
          kbd.key_code_o  <= emit_code;
          kbd.key_valid_o <= 1'b1;
        end else begin
          kbd.key_overrun_o <= 1'b1;
        end
      end else if (kbd.key_ack_in) begin
        kbd.key_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kbd_matrix_scan.sv
// Scoreboard bench for kbd_matrix_scan: a key matrix model drives rows from the column strobe.
module tb_kbd_matrix_scan;
  localparam int FRAME = 40;
`ifdef KBD_RELEASE_EVENT_EN
  localparam int REL_EV = 1;
`else
  localparam int REL_EV = 0;
`endif

  logic            clk_in = 1'b0;
  logic            reset_in = 1'b1;
  logic [4:0]      kbd_columns_o;
  logic [3:0]      rowsl_in, rowsr_in;
  logic [4:0][7:0] pressed;
  logic [7:0]      row_vec;

  kbd_matrix_scan_if kbd();

  kbd_matrix_scan #(.SETTLE_CYCLES(8), .DEBOUNCE_SCANS(4)) dut (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .kbd_columns_o (kbd_columns_o),
    .rowsl_in      (rowsl_in),
    .rowsr_in      (rowsr_in),
    .kbd           (kbd)
  );

  always #5 clk_in = ~clk_in;

  always_comb begin
    row_vec = '0;
    for (int c = 0; c < 5; c++) begin
      if (kbd_columns_o[c]) row_vec = row_vec | pressed[c];
    end
  end
  assign rowsl_in = row_vec[3:0];
  assign rowsr_in = row_vec[7:4];

  int         vectors = 0;
  int         miscompares = 0;
  int         rise_cnt = 0;
  int         ovr_cnt = 0;
  int         down_cycles = 0;
  logic       valid_d = 1'b0;
  logic [6:0] exp_q[$];

  always @(posedge clk_in) begin
    #2;
    if (kbd.key_overrun_o) ovr_cnt++;
    if (kbd.key_valid_o && !valid_d) rise_cnt++;
    if (kbd.key_down_o) down_cycles++;
    valid_d = kbd.key_valid_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic wait_valid(input string tag, input int budget, output int n);
    n = 0;
    while (!kbd.key_valid_o && n < budget) begin
      step(1);
      n++;
    end
    check({tag, "_valid"}, 32'(kbd.key_valid_o), 1);
  endtask

  task automatic wait_down(input string tag, input logic val, input int budget);
    int n = 0;
    while (kbd.key_down_o !== val && n < budget) begin
      step(1);
      n++;
    end
    check(tag, 32'(kbd.key_down_o), 32'(val));
  endtask

  task automatic wait_cols(input string tag, input logic [4:0] val, input int budget);
    int n = 0;
    while (kbd_columns_o !== val && n < budget) begin
      step(1);
      n++;
    end
    check(tag, 32'(kbd_columns_o), 32'(val));
  endtask

  // Pop the scoreboard against the pending event, hold it ack_delay clocks, then acknowledge.
  task automatic take_event(input string tag, input int budget, input int ack_delay);
    int n;
    logic [6:0] exp;
    wait_valid(tag, budget, n);
    if (kbd.key_valid_o) begin
      if (exp_q.size() == 0) begin
        check({tag, "_unexpected"}, 32'(kbd.key_code_o), 32'h7f);
      end else begin
        exp = exp_q.pop_front();
        check({tag, "_code"}, 32'(kbd.key_code_o), 32'(exp));
      end
      step(ack_delay);
      check({tag, "_held"}, 32'(kbd.key_valid_o), 1);
      kbd.key_ack_in = 1'b1;
      step(1);
      kbd.key_ack_in = 1'b0;
      check({tag, "_clr"}, 32'(kbd.key_valid_o), 0);
    end
  endtask

  initial begin
    int lat, r0, o0, d0;
    pressed = '0;
    kbd.key_ack_in = 1'b0;

    step(3);
    check("rst_cols", 32'(kbd_columns_o), 0);
    check("rst_code", 32'(kbd.key_code_o), 0);
    check("rst_valid", 32'(kbd.key_valid_o), 0);
    check("rst_down", 32'(kbd.key_down_o), 0);
    check("rst_ovr", 32'(kbd.key_overrun_o), 0);
    reset_in = 1'b0;

    for (int k = 1; k <= 48; k++) begin
      step(1);
      check("col_seq", 32'(kbd_columns_o), 32'(5'b00001 << (((k - 1) / 8) % 5)));
    end

    kbd.key_ack_in = 1'b1;
    step(1);
    kbd.key_ack_in = 1'b0;
    check("ack_idle_valid", 32'(kbd.key_valid_o), 0);

    // Reset mid-frame with col 2 row 5 held, then keep holding for ten frames.
    pressed[2][5] = 1'b1;
    exp_q.push_back(7'h15);
    wait_cols("t3_col3", 5'b01000, 60);
    reset_in = 1'b1;
    step(1);
    check("t3_rst_cols", 32'(kbd_columns_o), 0);
    check("t3_rst_valid", 32'(kbd.key_valid_o), 0);
    step(3);
    reset_in = 1'b0;
    r0 = rise_cnt;
    step(1);
    check("t3_first_col", 32'(kbd_columns_o), 32'h01);
    wait_valid("t3", 250, lat);
    lat += 1;
    check("t3_latency_ok", 32'(lat >= 4 * FRAME && lat <= 4 * FRAME + 5), 1);
    take_event("t3", 5, 5);
    step(10 * FRAME - lat - 8);
    check("t4_one_event", 32'(rise_cnt - r0), 1);
    check("t4_down_held", 32'(kbd.key_down_o), 1);
    pressed = '0;
    if (REL_EV != 0) exp_q.push_back(7'h55);
    step(3 * FRAME);
    check("t4_down_after_3", 32'(kbd.key_down_o), 1);
    wait_down("t4_down_low", 1'b0, 3 * FRAME);
    if (REL_EV != 0) take_event("t4_rel", 5, 2);
    else check("t4_no_rel", 32'(kbd.key_valid_o), 0);

    // Bounce: two frames on, one off, four on; only the last run produces an event.
    wait_cols("t5_al4", 5'b10000, 2 * FRAME);
    wait_cols("t5_al0", 5'b00001, FRAME);
    r0 = rise_cnt;
    pressed[0][3] = 1'b1;
    step(2 * FRAME);
    pressed[0][3] = 1'b0;
    step(FRAME);
    pressed[0][3] = 1'b1;
    exp_q.push_back(7'h03);
    step(3 * FRAME + 30);
    check("t5_no_early", 32'(rise_cnt - r0), 0);
    take_event("t5", 30, 1);
    pressed = '0;
    if (REL_EV != 0) exp_q.push_back(7'h43);
    wait_down("t5_down_low", 1'b0, 6 * FRAME);
    if (REL_EV != 0) take_event("t5_rel", 5, 1);

    // Two keys together never qualify.
    r0 = rise_cnt;
    d0 = down_cycles;
    pressed[0][0] = 1'b1;
    pressed[4][7] = 1'b1;
    step(8 * FRAME);
    check("t6_no_event", 32'(rise_cnt - r0), 0);
    check("t6_down_cycles", 32'(down_cycles - d0), 0);
    pressed = '0;
    step(2 * FRAME);

    // Overrun: 0x0A left pending, then release (and 0x18 press) arrive while it is unacknowledged.
    o0 = ovr_cnt;
    pressed[1][2] = 1'b1;
    exp_q.push_back(7'h0A);
    wait_valid("t7_press", 6 * FRAME, lat);
    pressed = '0;
    wait_down("t7_rel", 1'b0, 6 * FRAME);
    pressed[3][0] = 1'b1;
    wait_down("t7_press2", 1'b1, 6 * FRAME);
    step(1);
    check("t7_overrun", 32'(ovr_cnt - o0), 32'(1 + REL_EV));
    check("t7_code_kept", 32'(kbd.key_code_o), 32'h0A);
    take_event("t7", 5, 1);
    pressed = '0;
    if (REL_EV != 0) exp_q.push_back(7'h58);
    wait_down("t7_rel2", 1'b0, 6 * FRAME);
    if (REL_EV != 0) take_event("t7_rel2", 5, 1);
    else check("t7_no_rel", 32'(kbd.key_valid_o), 0);

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
